// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: serves cache line fills and write-through words from a word-wide SRAM, adding a programmable access latency.
module main_mem_ctrl #(
  parameter int ACCESS_LAT = 2,
  parameter int SRAM_AW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic               mem_read_req,
  input  logic               mem_write_req,
  output logic [511:0]       mem_line_data,
  output logic               mem_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               sram_we,
  input  logic [31:0]        sram_rdata
);
  localparam int LW = (ACCESS_LAT < 2) ? 1 : $clog2(ACCESS_LAT);
  typedef enum logic [2:0] {IDLE, LAT, FILL, WRITE, DONE} state_t;
  state_t             state_q, state_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [3:0]         beat_q, beat_d, cap_idx;
  logic               last_q, last_d, rd_q, rd_d;
  logic [SRAM_AW-1:0] wa_q, wa_d;
  logic [31:0]        wd_q, wd_d;
  logic [511:0]       shadow_q, shadow_d, line_q, line_d;
  logic               unused_addr;
  assign unused_addr = ^{mem_addr[31:SRAM_AW+2], mem_addr[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      beat_q   <= '0;
      last_q   <= 1'b0;
      rd_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      shadow_q <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      rd_q     <= rd_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      shadow_q <= shadow_d;
      line_q   <= line_d;
    end
  end
  // Read data trails its address by one cycle, so each FILL cycle stores the previous beat.
  assign cap_idx = last_q ? 4'hf : beat_q - 4'd1;
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    last_d   = last_q;
    rd_d     = rd_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    shadow_d = shadow_q;
    line_d   = line_q;
    case (state_q)
      IDLE: if (mem_read_req || mem_write_req) begin
        rd_d    = mem_read_req;
        wa_d    = mem_addr[SRAM_AW+1:2];
        wd_d    = mem_read_req ? wd_q : mem_wdata;
        lat_d   = LW'(ACCESS_LAT - 1);
        state_d = (ACCESS_LAT == 0) ? (mem_read_req ? FILL : WRITE) : LAT;
      end
      LAT: if (lat_q == '0) state_d = rd_q ? FILL : WRITE;
           else lat_d = lat_q - LW'(1);
      FILL: begin
        if (beat_q != 4'd0 || last_q) shadow_d[{cap_idx, 5'b0} +: 32] = sram_rdata;
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
          beat_d  = 4'd0;
          line_d  = {sram_rdata, shadow_q[479:0]};
        end else if (beat_q == 4'hf) last_d = 1'b1;
        else beat_d = beat_q + 4'd1;
      end
      WRITE: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign mem_ready     = state_q == DONE;
  assign mem_line_data = line_q;
  assign sram_we       = state_q == WRITE;
  assign sram_wdata    = state_q == WRITE ? wd_q : '0;
  assign sram_addr     = state_q == FILL ? {wa_q[SRAM_AW-1:4], beat_q} : state_q == WRITE ? wa_q : '0;
endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Main-memory side controller for the L1 cache controller's miss/write-through port. It serves two kinds of request from the cache controller. A line-fill read returns a 512-bit line assembled from sixteen 32-bit beats. A write-through stores a single 32-bit word. Downstream it drives a word-wide synchronous SRAM with 1-cycle read latency, and it adds a programmable access latency so the cache controller sees realistic memory stall times.

## Interface
- ACCESS_LAT, 2: idle cycles inserted after request acceptance, before SRAM access; 0 allowed.
- SRAM_AW, 12: SRAM word-address width; byte address bits above SRAM_AW+1 are ignored (aliasing).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from cache controller.
- mem_wdata  in  32  write-through data word.
- mem_read_req  in  1  line-fill request; level, held until ready.
- mem_write_req  in  1  word-write request; level, held until ready.
- mem_line_data  out  512  filled line; word i at bits [32i+31:32i].
- mem_ready  out  1  one-cycle completion pulse.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_we  out  1  SRAM write enable.
- sram_rdata  in  32  SRAM read data, valid the cycle after its address is presented.

## Operation
- States: IDLE, LAT, FILL, WRITE, DONE.
- IDLE:
  - samples requests each edge; mem_read_req has priority over mem_write_req.
  - A write held while a read is accepted is served after the read completes, provided it is still asserted.
  - On acceptance, latch the address (and the data for a write), then go to LAT. If ACCESS_LAT=0, go directly to FILL or WRITE.
- LAT: a down-counter runs ACCESS_LAT cycles, then goes to FILL (read) or WRITE (write).
- FILL:
  - Line base = {addr[31:6], 6'b0}.
  - 4-bit beat counter issues sram_addr = (base>>2)+i for i=0..15 on consecutive cycles.
  - sram_rdata for beat i is captured into word i one cycle later.
  - 17 cycles total: 16 issue cycles plus the final capture. Then go to DONE.
- Line assembly: words are written into a shadow register. mem_line_data updates atomically on entry to DONE. It holds the last completed line until the next fill completes, and writes do not alter it.
- WRITE:
  - One cycle with sram_we=1, sram_addr = addr[SRAM_AW+1:2], sram_wdata = latched data.
  - addr[1:0] is ignored. Then go to DONE.
- DONE: mem_ready=1 for exactly one cycle, then IDLE.
  - The requester must drop its request on the edge where it samples mem_ready=1.
  - A request still high in the following IDLE cycle is treated as a new request.
- Beat counter wraps 15→0 only at FILL exit. No partial-line or burst-across-line behaviour.
- sram_we is asserted only in WRITE, never during FILL/LAT/IDLE/DONE.

## Timing
- Reset values: mem_ready=0, mem_line_data=0, sram_we=0, sram_addr=0, sram_wdata=0, state=IDLE, counters=0.
- Read: request accepted at edge E0; mem_ready high in the cycle after edge E0+ACCESS_LAT+17. Default: 19 cycles.
- Write: mem_ready high after edge E0+ACCESS_LAT+1. Default: 3 cycles.
- Back-to-back throughput: the next request can be accepted at the earliest 2 edges after the DONE cycle begins (DONE then IDLE).
- rst asserted mid-LAT/FILL/WRITE:
  - next state IDLE, all outputs take reset values, any partially assembled line is discarded, and no mem_ready is generated.
  - An SRAM write already issued in WRITE on that edge is not undone.
- Requests deasserted before completion are protocol violations. The transaction still completes and pulses mem_ready.

## Test plan
- SRAM word k preloaded with 4k. Read 0x00001000 → after 19 cycles mem_ready pulses once; mem_line_data word i = 0x1000+4i; sram_addr stepped 0x400..0x40F.
- Write 0x00002000 data 0xDEADBEEF → sram_we high exactly one cycle with sram_addr=0x800, sram_wdata=0xDEADBEEF; mem_ready 3 cycles after acceptance. Then read 0x00002000 → word0=0xDEADBEEF, word1=0x2004; mem_line_data from the prior fill remains unchanged until this fill completes.
- mem_read_req and mem_write_req both high at 0x3000 → read served first (ready after 19 cycles); write still held is then served (sram_we once, ready pulse); exactly two ready pulses.
- Unaligned read at 0x0000103C → identical line to 0x1000; write at 0x00002003 → sram_addr=0x800.
- rst asserted at beat 7 of a fill → no mem_ready, sram_we=0, mem_line_data=0. A fresh read of 0x1000 then completes normally in 19 cycles.
- ACCESS_LAT=0 build: read ready after 17 cycles, write ready after 1 cycle; address aliasing at 0x00004000 (SRAM_AW=12) reads the same line as 0x0000.
